// File: rtl/motion_seg_scheduler.sv
// Segment FIFO plus IDLE/LOAD/RUN sequencer feeding the motion step generator.
// Segments are popped into held Seg_* registers and announced with a one-cycle Seg_Load.
module motion_seg_scheduler #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          Bus2IP_Clk,
  input  logic          Bus2IP_Resetn,
  input  logic          Push_Valid,
  output logic          Push_Ready,
  input  logic [31:0]   Push_V,
  input  logic [31:0]   Push_A,
  input  logic [31:0]   Push_J,
  input  logic [31:0]   Push_Dt,
  input  logic [31:0]   Push_Steps,
  input  logic          Push_Last,
  input  logic          Start,
  input  logic          Abort,
  input  logic          Count_Clr,
  input  logic          Core_Done,
  output logic          Seg_Load,
  output logic [31:0]   Seg_V,
  output logic [31:0]   Seg_A,
  output logic [31:0]   Seg_J,
  output logic [31:0]   Seg_Dt,
  output logic [31:0]   Seg_Steps,
  output logic [AW:0]   Level,
  output logic          Busy,
  output logic [31:0]   Seg_Count,
  output logic          Ev_Finished,
  output logic          Ev_Underrun
);

  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] Full = LW'(DEPTH);

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] j;
    logic [31:0] dt;
    logic [31:0] steps;
    logic        last;
  } seg_t;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e        state_q, state_d;
  seg_t          mem_q [DEPTH];
  seg_t          cur_q;
  seg_t          push_seg;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [31:0]   count_q, count_d;
  logic          load_q, load_d;
  logic          fin_q, fin_d;
  logic          und_q, und_d;
  logic          push, pop, count_evt, not_empty;

  assign push_seg   = '{v: Push_V, a: Push_A, j: Push_J, dt: Push_Dt, steps: Push_Steps,
                        last: Push_Last};
  assign not_empty  = (level_q != '0);
  // Ready is a pure function of the registered level, never of a same-cycle pop.
  assign Push_Ready = (level_q != Full);
  assign push       = Push_Valid && Push_Ready && !Abort;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_d    = 1'b0;
    fin_d     = 1'b0;
    und_d     = 1'b0;
    count_evt = 1'b0;
    if (Abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start && not_empty) state_d = StLoad;
        end
        StLoad: begin
          pop     = 1'b1;
          load_d  = 1'b1;
          state_d = StRun;
        end
        StRun: begin
          if (Core_Done) begin
            count_evt = 1'b1;
            if (cur_q.last) begin
              fin_d   = 1'b1;
              state_d = StIdle;
            end else if (not_empty) begin
              pop    = 1'b1;
              load_d = 1'b1;
            end else begin
              und_d   = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    if (Abort) begin
      level_d = '0;
    end else begin
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_comb begin
    count_d = count_q;
    if (Count_Clr) begin
      count_d = '0;
    end else if (count_evt) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
      load_q   <= 1'b0;
      fin_q    <= 1'b0;
      und_q    <= 1'b0;
      cur_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      count_q <= count_d;
      load_q  <= load_d;
      fin_q   <= fin_d;
      und_q   <= und_d;
      if (Abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= push_seg;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          cur_q    <= mem_q[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

  assign Seg_Load    = load_q;
  assign Seg_V       = cur_q.v;
  assign Seg_A       = cur_q.a;
  assign Seg_J       = cur_q.j;
  assign Seg_Dt      = cur_q.dt;
  assign Seg_Steps   = cur_q.steps;
  assign Level       = level_q;
  assign Busy        = (state_q != StIdle);
  assign Seg_Count   = count_q;
  assign Ev_Finished = fin_q;
  assign Ev_Underrun = und_q;

endmodule

// File: tb/tb_motion_seg_scheduler.sv
// Self-checking bench for motion_seg_scheduler: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_motion_seg_scheduler;

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] j;
    logic [31:0] dt;
    logic [31:0] steps;
    logic        last;
  } seg_t;

  typedef struct {
    bit          pv;
    logic [31:0] steps;
    bit          last;
    bit          st;
    bit          ab;
    bit          cc;
    bit          cd;
    int          lvl;
    bit          busy;
    bit          ld;
    bit          fin;
    bit          und;
    logic [31:0] cnt;
    logic [31:0] seg_steps;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid, push_ready, push_last;
  logic [31:0] push_v, push_a, push_j, push_dt, push_steps;
  logic        start, abort, count_clr, core_done;
  logic        seg_load, busy, ev_finished, ev_underrun;
  logic [31:0] seg_v, seg_a, seg_j, seg_dt, seg_steps, seg_count;
  logic [3:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of segments plus the sequencer's mode.
  seg_t        mq[$];
  int          m_mode;  // 0 idle, 1 loading, 2 running
  seg_t        m_cur;
  logic [31:0] m_count;
  bit          m_load, m_fin, m_und;

  motion_seg_scheduler #(.DEPTH(8), .AW(3)) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Resetn(rst_n),
    .Push_Valid   (push_valid),
    .Push_Ready   (push_ready),
    .Push_V       (push_v),
    .Push_A       (push_a),
    .Push_J       (push_j),
    .Push_Dt      (push_dt),
    .Push_Steps   (push_steps),
    .Push_Last    (push_last),
    .Start        (start),
    .Abort        (abort),
    .Count_Clr    (count_clr),
    .Core_Done    (core_done),
    .Seg_Load     (seg_load),
    .Seg_V        (seg_v),
    .Seg_A        (seg_a),
    .Seg_J        (seg_j),
    .Seg_Dt       (seg_dt),
    .Seg_Steps    (seg_steps),
    .Level        (level),
    .Busy         (busy),
    .Seg_Count    (seg_count),
    .Ev_Finished  (ev_finished),
    .Ev_Underrun  (ev_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode  = 0;
    m_cur   = '0;
    m_count = '0;
    m_load  = 0;
    m_fin   = 0;
    m_und   = 0;
  endtask

  task automatic model_update();
    int   sz;
    bit   evt;
    seg_t s;
    sz     = mq.size();
    evt    = 0;
    m_load = 0;
    m_fin  = 0;
    m_und  = 0;
    if (abort) begin
      mq.delete();
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (start && sz > 0) m_mode = 1;
        1: begin
          m_cur  = mq.pop_front();
          m_load = 1;
          m_mode = 2;
        end
        default: begin
          if (core_done) begin
            evt = 1;
            if (m_cur.last) begin
              m_fin  = 1;
              m_mode = 0;
            end else if (sz > 0) begin
              m_cur  = mq.pop_front();
              m_load = 1;
            end else begin
              m_und  = 1;
              m_mode = 0;
            end
          end
        end
      endcase
      if (push_valid && sz < 8) begin
        s.v = push_v; s.a = push_a; s.j = push_j; s.dt = push_dt;
        s.steps = push_steps; s.last = push_last;
        mq.push_back(s);
      end
    end
    if (count_clr) m_count = '0;
    else if (evt) m_count = m_count + 32'd1;
  endtask

  task automatic compare_all();
    chk("push_ready", {31'd0, push_ready}, {31'd0, mq.size() < 8});
    chk("level", {28'd0, level}, mq.size());
    chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
    chk("seg_load", {31'd0, seg_load}, {31'd0, m_load});
    chk("ev_finished", {31'd0, ev_finished}, {31'd0, m_fin});
    chk("ev_underrun", {31'd0, ev_underrun}, {31'd0, m_und});
    chk("seg_count", seg_count, m_count);
    chk("seg_v", seg_v, m_cur.v);
    chk("seg_a", seg_a, m_cur.a);
    chk("seg_j", seg_j, m_cur.j);
    chk("seg_dt", seg_dt, m_cur.dt);
    chk("seg_steps", seg_steps, m_cur.steps);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    push_valid = 0; push_last = 0; start = 0; abort = 0; count_clr = 0; core_done = 0;
  endtask

  task automatic push_seg(input logic [31:0] steps, input bit last);
    push_valid = 1; push_steps = steps; push_last = last;
    push_v = $urandom; push_a = $urandom; push_j = $urandom; push_dt = $urandom;
    step();
    idle_inputs();
  endtask

  vec_t tbl[15];

  initial begin
    idle_inputs();
    push_v = 0; push_a = 0; push_j = 0; push_dt = 0; push_steps = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1;

    //          pv steps last st ab cc cd lvl busy ld fin und cnt seg_steps
    tbl[0]  = '{1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 20, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 30, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0,  0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0,  0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 10};
    tbl[5]  = '{0, 0,  0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 10};
    tbl[6]  = '{0, 0,  0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 20};
    tbl[7]  = '{0, 0,  0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 2, 30};
    tbl[8]  = '{0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3, 30};
    tbl[9]  = '{1, 5,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 30};
    tbl[10] = '{0, 0,  0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 3, 30};
    tbl[11] = '{0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 5};
    tbl[12] = '{0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 5};
    tbl[13] = '{0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5};
    tbl[14] = '{0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};

    push_v = 100; push_a = 32'hFFFF_FFFE; push_j = 3; push_dt = 50;
    for (int i = 0; i < 15; i++) begin
      push_valid = tbl[i].pv; push_steps = tbl[i].steps; push_last = tbl[i].last;
      start = tbl[i].st; abort = tbl[i].ab; count_clr = tbl[i].cc; core_done = tbl[i].cd;
      step();
      chk($sformatf("tbl%0d.level", i), {28'd0, level}, tbl[i].lvl);
      chk($sformatf("tbl%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d.seg_load", i), {31'd0, seg_load}, {31'd0, tbl[i].ld});
      chk($sformatf("tbl%0d.ev_fin", i), {31'd0, ev_finished}, {31'd0, tbl[i].fin});
      chk($sformatf("tbl%0d.ev_und", i), {31'd0, ev_underrun}, {31'd0, tbl[i].und});
      chk($sformatf("tbl%0d.count", i), seg_count, tbl[i].cnt);
      chk($sformatf("tbl%0d.steps", i), seg_steps, tbl[i].seg_steps);
    end
    idle_inputs();
    chk("underrun_seg_v_hold", seg_v, 32'd100);

    // Fill to DEPTH, then a ninth push must be dropped.
    for (int i = 0; i < 8; i++) push_seg(32'd100 + i, 0);
    chk("full_ready", {31'd0, push_ready}, 32'd0);
    push_seg(32'd999, 0);
    chk("full_drop_level", {28'd0, level}, 32'd8);
    start = 1; step(); idle_inputs(); step();
    chk("first_pop_steps", seg_steps, 32'd100);
    push_seg(32'd108, 0);
    chk("refill_level", {28'd0, level}, 32'd8);
    // Pop while full: push is refused because ready is level-only.
    core_done = 1; push_valid = 1; push_steps = 32'd777; step(); idle_inputs();
    chk("full_pop_level", {28'd0, level}, 32'd7);
    // Push and pop on the same edge below full: level unchanged.
    core_done = 1; push_valid = 1; push_steps = 32'd109; step(); idle_inputs();
    chk("pushpop_level", {28'd0, level}, 32'd7);
    for (int i = 0; i < 12; i++) begin
      core_done = 1; step(); idle_inputs();
    end

    // Abort while running with 5 queued, with a coincident push.
    for (int i = 0; i < 6; i++) push_seg(32'd200 + i, 0);
    start = 1; step(); idle_inputs(); step();
    chk("abort_pre_level", {28'd0, level}, 32'd5);
    abort = 1; push_valid = 1; push_steps = 32'd555; step(); idle_inputs();
    chk("abort_level", {28'd0, level}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_load", {31'd0, seg_load}, 32'd0);
    core_done = 1; step(); idle_inputs();
    chk("abort_cd_ignored", seg_count, m_count);

    // Start on empty is ignored; negative accel passes through unmodified.
    start = 1; step(); idle_inputs();
    chk("empty_start_busy", {31'd0, busy}, 32'd0);
    push_valid = 1; push_a = 32'hFFFF_FFFF; push_steps = 7; push_last = 1; step(); idle_inputs();
    start = 1; step(); idle_inputs(); step();
    chk("neg_a", seg_a, 32'hFFFF_FFFF);
    core_done = 1; step(); idle_inputs();

    // Asynchronous reset between clock edges while running.
    for (int i = 0; i < 3; i++) push_seg(32'd300 + i, 0);
    start = 1; step(); idle_inputs(); step();
    core_done = 1; step(); idle_inputs();
    #3 rst_n = 0;
    #1;
    chk("rst_count", seg_count, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_seg_v", seg_v, 32'd0);
    chk("rst_seg_steps", seg_steps, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("rst_ready", {31'd0, push_ready}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      push_valid = ($urandom_range(0, 1) == 1);
      push_v = $urandom; push_a = $urandom; push_j = $urandom; push_dt = $urandom;
      push_steps = $urandom; push_last = ($urandom_range(0, 3) == 0);
      start      = ($urandom_range(0, 3) == 0);
      core_done  = ($urandom_range(0, 4) == 0);
      abort      = ($urandom_range(0, 49) == 0);
      count_clr  = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
